// File: rtl/mv_pkg.sv
// Shared types and helpers for the matrix-vector sequencer.
// Holds the FSM state enum, default parameters and the saturating narrow.
package mv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_VEC,
    S_ROW_PRE,
    S_ROW_RD,
    S_ROW_DRAIN,
    S_ROW_WR,
    S_DONE
  } state_e;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_MAX_DIM     = 64;
  localparam int DEF_FRAC_BITS   = 0;
  localparam int DEF_WADDR_WIDTH = 13;

  // Wide container so any accumulator width can be clamped in one place.
  localparam int SAT_W = 128;

  typedef struct packed {
    logic        sat;
    logic [31:0] val;
  } narrow_t;

  // Clamp v to a signed dw-bit range; val is sign-extended to 32 bits.
  function automatic narrow_t sat_narrow(
    input logic signed [SAT_W-1:0] v,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] one;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    narrow_t r;
    one = {{(SAT_W-1){1'b0}}, 1'b1};
    hi  = (one << (dw - 1)) - one;
    lo  = ~hi;
    r.sat = 1'b0;
    r.val = v[31:0];
    if (v > hi) begin
      r.sat = 1'b1;
      r.val = hi[31:0];
    end else if (v < lo) begin
      r.sat = 1'b1;
      r.val = lo[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/mv_mac_lane.sv
// Single MAC lane: preload/clear, multiply-accumulate, shift and clamp.
// Ports: load_i/load_val_i preload, mac_i/a_i/b_i accumulate, wr_i samples
// the clamp into the sticky sat_o, sat_clr_i clears it; res_o is the result.
module mv_mac_lane
  import mv_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+8,
  parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] load_val_i,
  input  logic                  mac_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  input  logic                  wr_i,
  input  logic                  sat_clr_i,
  output logic [31:0]           res_o,
  output logic                  sat_o
);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] a_ext, b_ext, ld_ext;
  logic signed [ACC_WIDTH-1:0] prod, sh;
  logic signed [SAT_W-1:0]     wide;
  narrow_t                     nar;
  logic                        sat_q, sat_d;

  assign a_ext  = ACC_WIDTH'($signed(a_i));
  assign b_ext  = ACC_WIDTH'($signed(b_i));
  assign ld_ext = ACC_WIDTH'($signed(load_val_i));
  assign prod   = a_ext * b_ext;
  assign sh     = acc_q >>> FRAC_BITS;
  assign wide   = SAT_W'(sh);
  assign nar    = sat_narrow(wide, DATA_WIDTH);

  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = ld_ext;
    end else if (mac_i) begin
      acc_d = acc_q + prod;
    end
  end

  always_comb begin
    sat_d = sat_q;
    if (sat_clr_i) begin
      sat_d = 1'b0;
    end else if (wr_i && nar.sat) begin
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      sat_q <= sat_d;
    end
  end

  assign res_o = nar.val;
  assign sat_o = sat_q;

endmodule

// File: rtl/mv_seq_con.sv
// Matrix-vector sequencer: y = M*x (+ y_old) over a single-port BRAM.
// Ports: start/cfg_* job setup, busy/done/err/sat status, BRAM_* memory.
module mv_seq_con
  import mv_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MAX_DIM     = DEF_MAX_DIM,
  parameter int ACC_WIDTH   = 2*DATA_WIDTH+8,
  parameter int FRAC_BITS   = DEF_FRAC_BITS,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic [7:0]             cfg_rows,
  input  logic [7:0]             cfg_cols,
  input  logic                   cfg_accum,
  input  logic [WADDR_WIDTH-1:0] cfg_mat_base,
  input  logic [WADDR_WIDTH-1:0] cfg_vec_base,
  input  logic [WADDR_WIDTH-1:0] cfg_res_base,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   sat,
  output logic [31:0]            BRAM_ADDR,
  output logic [31:0]            BRAM_WRDATA,
  output logic [3:0]             BRAM_WE,
  input  logic [31:0]            BRAM_RDDATA
);

  localparam int IW = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  state_e                 state_q, state_d;
  logic [7:0]             rows_q, rows_d;
  logic [7:0]             cols_q, cols_d;
  logic                   accum_q, accum_d;
  logic [WADDR_WIDTH-1:0] mat_a_q, mat_a_d;
  logic [WADDR_WIDTH-1:0] vec_b_q, vec_b_d;
  logic [WADDR_WIDTH-1:0] res_b_q, res_b_d;
  logic [7:0]             c_q, c_d;
  logic [7:0]             r_q, r_d;
  logic                   vwr_q, vwr_d;
  logic [IW-1:0]          vidx_q, vidx_d;
  logic                   mac_q, mac_d;
  logic                   err_q, err_d;

  logic [DATA_WIDTH-1:0]  vram [MAX_DIM];
  logic [DATA_WIDTH-1:0]  x_q;
  logic                   vrd_en;

  logic [WADDR_WIDTH-1:0] waddr;
  logic                   wr_en;
  logic                   ld_en;
  logic                   sat_clr;
  logic                   dims_ok;
  logic [31:0]            res;
  logic                   lane_sat;
  logic [DATA_WIDTH-1:0]  rd_el;
  logic                   unused_rd;

  assign rd_el     = BRAM_RDDATA[DATA_WIDTH-1:0];
  assign unused_rd = ^BRAM_RDDATA;

  assign dims_ok = (cfg_rows != 8'd0) && (int'(cfg_rows) <= MAX_DIM)
                && (cfg_cols != 8'd0) && (int'(cfg_cols) <= MAX_DIM);

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    accum_d = accum_q;
    mat_a_d = mat_a_q;
    vec_b_d = vec_b_q;
    res_b_d = res_b_q;
    c_d     = c_q;
    r_d     = r_q;
    vwr_d   = 1'b0;
    vidx_d  = vidx_q;
    mac_d   = 1'b0;
    err_d   = 1'b0;
    waddr   = '0;
    wr_en   = 1'b0;
    ld_en   = 1'b0;
    vrd_en  = 1'b0;
    sat_clr = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && dims_ok) begin
          rows_d  = cfg_rows;
          cols_d  = cfg_cols;
          accum_d = cfg_accum;
          mat_a_d = cfg_mat_base;
          vec_b_d = cfg_vec_base;
          res_b_d = cfg_res_base;
          c_d     = 8'd0;
          r_d     = 8'd0;
          sat_clr = 1'b1;
          state_d = S_LOAD_VEC;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      S_LOAD_VEC: begin
        if (c_q != cols_q) begin
          waddr  = vec_b_q + WADDR_WIDTH'(c_q);
          vwr_d  = 1'b1;
          vidx_d = c_q[IW-1:0];
          c_d    = c_q + 8'd1;
        end else begin
          c_d     = 8'd0;
          state_d = accum_q ? S_ROW_PRE : S_ROW_RD;
        end
      end
      S_ROW_PRE: begin
        waddr   = res_b_q + WADDR_WIDTH'(r_q);
        state_d = S_ROW_RD;
      end
      S_ROW_RD: begin
        // c==0 sees the preload word (or nothing) on the read bus.
        ld_en   = (c_q == 8'd0);
        waddr   = mat_a_q;
        mat_a_d = mat_a_q + 1'b1;
        vrd_en  = 1'b1;
        mac_d   = 1'b1;
        c_d     = c_q + 8'd1;
        if (c_q == cols_q - 8'd1) begin
          state_d = S_ROW_DRAIN;
        end
      end
      S_ROW_DRAIN: begin
        state_d = S_ROW_WR;
      end
      S_ROW_WR: begin
        waddr = res_b_q + WADDR_WIDTH'(r_q);
        wr_en = 1'b1;
        if (r_q == rows_q - 8'd1) begin
          state_d = S_DONE;
        end else begin
          r_d     = r_q + 8'd1;
          c_d     = 8'd0;
          state_d = accum_q ? S_ROW_PRE : S_ROW_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      rows_q  <= '0;
      cols_q  <= '0;
      accum_q <= 1'b0;
      mat_a_q <= '0;
      vec_b_q <= '0;
      res_b_q <= '0;
      c_q     <= '0;
      r_q     <= '0;
      vwr_q   <= 1'b0;
      vidx_q  <= '0;
      mac_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      accum_q <= accum_d;
      mat_a_q <= mat_a_d;
      vec_b_q <= vec_b_d;
      res_b_q <= res_b_d;
      c_q     <= c_d;
      r_q     <= r_d;
      vwr_q   <= vwr_d;
      vidx_q  <= vidx_d;
      mac_q   <= mac_d;
      err_q   <= err_d;
    end
  end

  // Vector RAM: written one cycle after each x read, read alongside M.
  always_ff @(posedge aclk) begin
    if (vwr_q) begin
      vram[vidx_q] <= rd_el;
    end
    if (vrd_en) begin
      x_q <= vram[c_q[IW-1:0]];
    end
  end

  mv_mac_lane #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH),
    .FRAC_BITS  (FRAC_BITS)
  ) u_lane (
    .clk_i      (aclk),
    .rst_ni     (aresetn),
    .load_i     (ld_en),
    .load_val_i (accum_q ? rd_el : '0),
    .mac_i      (mac_q),
    .a_i        (rd_el),
    .b_i        (x_q),
    .wr_i       (wr_en),
    .sat_clr_i  (sat_clr),
    .res_o      (res),
    .sat_o      (lane_sat)
  );

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
  assign err  = err_q;
  assign sat  = done & lane_sat;

  assign BRAM_ADDR   = 32'(waddr) << 2;
  assign BRAM_WRDATA = wr_en ? res : 32'h0;
  assign BRAM_WE     = wr_en ? 4'hF : 4'h0;

endmodule

// File: tb/tb_mv_seq_con.sv
// Scoreboard bench for mv_seq_con: three instances (32b, 16b, 32b frac 4).
// Stimulus queues expected writes/done/err; a negedge monitor checks them.
module tb_mv_seq_con;

  logic        aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn;
  logic [2:0]  start;
  logic [7:0]  cfg_rows, cfg_cols;
  logic        cfg_accum;
  logic [12:0] cfg_mat_base, cfg_vec_base, cfg_res_base;

  logic        busy  [3];
  logic        done  [3];
  logic        err   [3];
  logic        sat   [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  we    [3];
  logic [31:0] mem   [3][1024];

  typedef struct {
    int          g;
    int          kind;
    logic [31:0] a;
    logic [31:0] d;
    int          b;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   bcnt [3];

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int DW = (g == 1) ? 16 : 32;
    localparam int FB = (g == 2) ? 4 : 0;
    logic [31:0] rdq;
    mv_seq_con #(
      .DATA_WIDTH (DW),
      .MAX_DIM    (64),
      .ACC_WIDTH  (2*DW+8),
      .FRAC_BITS  (FB),
      .WADDR_WIDTH(13)
    ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .start       (start[g]),
      .cfg_rows    (cfg_rows),
      .cfg_cols    (cfg_cols),
      .cfg_accum   (cfg_accum),
      .cfg_mat_base(cfg_mat_base),
      .cfg_vec_base(cfg_vec_base),
      .cfg_res_base(cfg_res_base),
      .busy        (busy[g]),
      .done        (done[g]),
      .err         (err[g]),
      .sat         (sat[g]),
      .BRAM_ADDR   (addr[g]),
      .BRAM_WRDATA (wdata[g]),
      .BRAM_WE     (we[g]),
      .BRAM_RDDATA (rdq)
    );
    always @(posedge aclk) rdq <= mem[g][addr[g][11:2]];
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic evt(input int g, input int kind, input logic [31:0] a,
                     input logic [31:0] d, input int b, input logic [3:0] w);
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_evt: dut%0d kind %0d a=%h d=%h, none expected",
               g, kind, a, d);
      return;
    end
    e = q.pop_front();
    chk("evt_dut", g, e.g);
    chk("evt_kind", kind, e.kind);
    if (kind == 0) begin
      chk("wr_addr", a, e.a);
      chk("wr_data", d, e.d);
      chk("wr_we", {28'h0, w}, 32'hF);
    end else if (kind == 1) begin
      chk("done_sat", d, e.d);
      chk("busy_cycles", b, e.b);
    end
  endtask

  always @(negedge aclk) begin
    for (int g = 0; g < 3; g++) begin
      if (!aresetn) begin
        bcnt[g] = 0;
      end else begin
        if (busy[g]) bcnt[g]++;
        if (we[g] != 4'h0) evt(g, 0, addr[g], wdata[g], 0, we[g]);
        if (done[g]) begin
          evt(g, 1, 32'h0, {31'h0, sat[g]}, bcnt[g], 4'h0);
          bcnt[g] = 0;
        end
        if (err[g]) evt(g, 2, 32'h0, 32'h0, 0, 4'h0);
      end
    end
  end

  task automatic exp_wr(input int g, input int wa, input logic [31:0] d);
    q.push_back('{g: g, kind: 0, a: 32'(wa) << 2, d: d, b: 0});
  endtask

  task automatic exp_done(input int g, input bit s, input int b);
    q.push_back('{g: g, kind: 1, a: 32'h0, d: {31'h0, s}, b: b});
  endtask

  task automatic exp_err(input int g);
    q.push_back('{g: g, kind: 2, a: 32'h0, d: 32'h0, b: 0});
  endtask

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic setcfg(input int r, input int c, input bit acc,
                        input int mb, input int vb, input int rb);
    cfg_rows     = 8'(r);
    cfg_cols     = 8'(c);
    cfg_accum    = acc;
    cfg_mat_base = 13'(mb);
    cfg_vec_base = 13'(vb);
    cfg_res_base = 13'(rb);
  endtask

  task automatic job(input int g, input int r, input int c, input bit acc,
                     input int mb, input int vb, input int rb);
    cyc();
    setcfg(r, c, acc, mb, vb, rb);
    start[g] = 1'b1;
    cyc();
    start[g] = 1'b0;
  endtask

  task automatic drain(input int g);
    int i;
    for (i = 0; i < 500; i++) begin
      if (q.size() == 0 && !busy[g] && !done[g]) break;
      cyc();
    end
    if (i == 500) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: dut%0d queue %0d left, expected 0",
               g, q.size());
      q.delete();
    end
    repeat (3) cyc();
  endtask

  initial begin
    aresetn = 1'b0;
    start   = 3'b0;
    setcfg(0, 0, 1'b0, 0, 0, 0);
    for (int g = 0; g < 3; g++)
      for (int i = 0; i < 1024; i++) mem[g][i] = 32'h0;

    // dut0 identity 4x4 at 0x000, x at 0x040
    for (int i = 0; i < 16; i++) mem[0][i] = (i % 5 == 0) ? 32'd1 : 32'd0;
    for (int i = 0; i < 4; i++) mem[0][16'h40 + i] = 32'(i + 1);
    // dut0 2x3 accum job
    mem[0][16'h10] = 32'd1; mem[0][16'h11] = 32'd1; mem[0][16'h12] = 32'd1;
    mem[0][16'h13] = 32'd2; mem[0][16'h14] = 32'd0;
    mem[0][16'h15] = 32'hFFFF_FFFF;
    mem[0][16'h50] = 32'd5; mem[0][16'h51] = 32'd6; mem[0][16'h52] = 32'd7;
    mem[0][16'h120] = 32'd10; mem[0][16'h121] = 32'hFFFF_FFFC;
    // dut0 2x2 held-start job
    mem[0][16'h20] = 32'd1; mem[0][16'h21] = 32'd2;
    mem[0][16'h22] = 32'd3; mem[0][16'h23] = 32'd4;
    mem[0][16'h60] = 32'd1; mem[0][16'h61] = 32'd1;
    // dut1 (16 bit) saturation cases
    mem[1][16'h00] = 32'h7FFF; mem[1][16'h40] = 32'h7FFF;
    mem[1][16'h01] = 32'd2;    mem[1][16'h41] = 32'd2;
    mem[1][16'h02] = 32'hFFFF_8000; mem[1][16'h42] = 32'h7FFF;
    // dut2 (frac 4)
    mem[2][16'h00] = 32'h35;        mem[2][16'h40] = 32'd1;
    mem[2][16'h01] = 32'hFFFF_FFCB; mem[2][16'h41] = 32'd1;

    repeat (3) cyc();
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", {31'h0, busy[g]}, 32'h0);
      chk("rst_done", {31'h0, done[g]}, 32'h0);
      chk("rst_err", {31'h0, err[g]}, 32'h0);
      chk("rst_sat", {31'h0, sat[g]}, 32'h0);
      chk("rst_addr", addr[g], 32'h0);
      chk("rst_wdata", wdata[g], 32'h0);
      chk("rst_we", {28'h0, we[g]}, 32'h0);
    end
    aresetn = 1'b1;
    repeat (2) cyc();

    // identity 4x4
    for (int i = 0; i < 4; i++) exp_wr(0, 16'h100 + i, 32'(i + 1));
    exp_done(0, 1'b0, 29);
    job(0, 4, 4, 1'b0, 16'h000, 16'h040, 16'h100);
    drain(0);

    // accumulate 2x3
    exp_wr(0, 16'h120, 32'd28);
    exp_wr(0, 16'h121, 32'hFFFF_FFFF);
    exp_done(0, 1'b0, 16);
    job(0, 2, 3, 1'b1, 16'h010, 16'h050, 16'h120);
    drain(0);

    // 16-bit saturation, then clean job clears sat, then negative clamp
    exp_wr(1, 16'h100, 32'h0000_7FFF);
    exp_done(1, 1'b1, 5);
    job(1, 1, 1, 1'b0, 16'h000, 16'h040, 16'h100);
    drain(1);
    exp_wr(1, 16'h101, 32'd4);
    exp_done(1, 1'b0, 5);
    job(1, 1, 1, 1'b0, 16'h001, 16'h041, 16'h101);
    drain(1);
    exp_wr(1, 16'h102, 32'hFFFF_8000);
    exp_done(1, 1'b1, 5);
    job(1, 1, 1, 1'b0, 16'h002, 16'h042, 16'h102);
    drain(1);

    // rejected dimensions
    exp_err(0);
    job(0, 4, 0, 1'b0, 16'h000, 16'h040, 16'h100);
    for (int i = 0; i < 3; i++) begin
      chk("bad_cols_busy", {31'h0, busy[0]}, 32'h0);
      chk("bad_cols_we", {28'h0, we[0]}, 32'h0);
      chk("bad_cols_addr", addr[0], 32'h0);
      cyc();
    end
    exp_err(0);
    job(0, 65, 4, 1'b0, 16'h000, 16'h040, 16'h100);
    for (int i = 0; i < 3; i++) begin
      chk("bad_rows_busy", {31'h0, busy[0]}, 32'h0);
      chk("bad_rows_we", {28'h0, we[0]}, 32'h0);
      chk("bad_rows_addr", addr[0], 32'h0);
      cyc();
    end
    drain(0);

    // reset during row 1 read phase aborts the job
    exp_wr(0, 16'h100, 32'd1);
    job(0, 4, 4, 1'b0, 16'h000, 16'h040, 16'h100);
    repeat (12) cyc();
    aresetn = 1'b0;
    #1;
    chk("abort_busy", {31'h0, busy[0]}, 32'h0);
    chk("abort_we", {28'h0, we[0]}, 32'h0);
    chk("abort_addr", addr[0], 32'h0);
    chk("abort_done", {31'h0, done[0]}, 32'h0);
    chk("abort_queue", q.size(), 0);
    cyc();
    aresetn = 1'b1;
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) exp_wr(0, 16'h100 + i, 32'(i + 1));
    exp_done(0, 1'b0, 29);
    job(0, 4, 4, 1'b0, 16'h000, 16'h040, 16'h100);
    drain(0);

    // start held high and re-pulsed: a single job
    exp_wr(0, 16'h140, 32'd3);
    exp_wr(0, 16'h141, 32'd7);
    exp_done(0, 1'b0, 11);
    cyc();
    setcfg(2, 2, 1'b0, 16'h020, 16'h060, 16'h140);
    start[0] = 1'b1;
    repeat (4) cyc();
    start[0] = 1'b0;
    cyc();
    start[0] = 1'b1;
    begin
      int i;
      for (i = 0; i < 200; i++) begin
        @(negedge aclk);
        if (done[0]) break;
      end
      if (i == 200) begin
        checks++;
        errors++;
        $display("FAIL held_start_done: no done in 200 cycles, expected one");
      end
    end
    start[0] = 1'b0;
    drain(0);
    repeat (10) cyc();

    // fractional shift: 0x35 >>> 4 = 3, -0x35 >>> 4 = -4
    exp_wr(2, 16'h100, 32'd3);
    exp_done(2, 1'b0, 5);
    job(2, 1, 1, 1'b0, 16'h000, 16'h040, 16'h100);
    drain(2);
    exp_wr(2, 16'h101, 32'hFFFF_FFFC);
    exp_done(2, 1'b0, 5);
    job(2, 1, 1, 1'b0, 16'h001, 16'h041, 16'h101);
    drain(2);

    repeat (5) cyc();
    chk("final_queue", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mv_seq_con.md
MV_SEQ_CON -- requirements
Module: mv_seq_con

Interface
REQ-001 Parameters (name, default, meaning):
- DATA_WIDTH, 32, signed element width (<=32, low bits of BRAM word).
- MAX_DIM, 64, maximum rows/cols.
- ACC_WIDTH, 2*DATA_WIDTH+8, accumulator width.
- FRAC_BITS, 0, fixed-point arithmetic right shift applied before output.
- WADDR_WIDTH, 13, BRAM word-address width.
REQ-002 Ports (name, direction, width, meaning):
- aclk  in  1  single clock; BRAM shares aclk.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  job request, sampled in IDLE only.
- cfg_rows, cfg_cols  in  8  matrix dimensions.
- cfg_accum  in  1  1 = y = M*x + y_old; 0 = y = M*x.
- cfg_mat_base, cfg_vec_base, cfg_res_base  in  WADDR_WIDTH  word bases; M is row-major.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on rejected config.
- sat  out  1  valid with done: any result saturated during the job.
- BRAM_ADDR  out  32  byte address = word address << 2.
- BRAM_WRDATA  out  32  result, sign-extended.
- BRAM_WE  out  4  4'hF on write cycles, else 0.
- BRAM_RDDATA  in  32  read data, 1-cycle latency.

Function
REQ-003 States: IDLE, LOAD_VEC, ROW_PRE (accum only), ROW_RD, ROW_DRAIN, ROW_WR, DONE.
REQ-004 IDLE -> LOAD_VEC on start with 1<=rows<=MAX_DIM and 1<=cols<=MAX_DIM; all cfg_* are latched on that edge.
REQ-005 Invalid dimensions on start: err pulses the next cycle; state remains IDLE; no BRAM access.
REQ-006 start outside IDLE is ignored.
REQ-007 LOAD_VEC: issue reads vec_base+0..cols-1 on consecutive cycles, plus 1 drain cycle; store each word into the local vector RAM at index c.
REQ-008 Per row r (0..rows-1), accum=1: ROW_PRE issues a read at res_base+r; that data preloads the accumulator. Accum=0: the accumulator is cleared at row start.
REQ-009 ROW_RD: issue a read at mat_base+r*cols+c for c=0..cols-1; read vector RAM[c] on the same cycle so operands align.
REQ-010 Each returning element: acc += M[r][c]*x[c]. Operands are sign-extended from DATA_WIDTH; the product is full width; wrap at ACC_WIDTH.
REQ-011 ROW_DRAIN: one cycle for the last product.
REQ-012 ROW_WR: write res = clamp(acc >>> FRAC_BITS) to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1] at res_base+r with BRAM_WE=4'hF.
- The sticky sat flag is set whenever the clamp engages.
- After the last row, go to DONE; otherwise go to the next row.
REQ-013 busy is high for exactly (cols+1) + rows*(cols+2+accum) cycles, starting the cycle after start is sampled.
REQ-014 DONE lasts 1 cycle: done=1 and sat valid, then IDLE; the sat flag clears on the next accepted start.
REQ-015 BRAM_ADDR = 0 and BRAM_WRDATA = 0 whenever no access is issued; at most one access per cycle.
REQ-016 Overlap of the result region with the M/x regions is undefined, except accum mode with identical y regions (read-before-write per row is guaranteed).

Reset
REQ-017 aresetn low asynchronously forces IDLE.
- Outputs go to 0: busy, done, err, sat, BRAM_ADDR, BRAM_WRDATA, BRAM_WE.
- The accumulator, counters and latched config are cleared; vector RAM contents need no reset.
REQ-018 Reset mid-job aborts the job: BRAM_WE drops to 0 immediately, no done pulse, and the first post-reset start runs normally.

Structure
REQ-019 Shared package mv_pkg holds:
- the state enum;
- default parameter constants;
- the saturating-narrow function.
REQ-020 One sub-module mv_mac_lane (clear/preload, accumulate, shift+saturate, sat output) is instantiated once.
REQ-021 Vector RAM is a MAX_DIM x DATA_WIDTH synchronous RAM, inferred as distributed or block RAM.

Verification
REQ-022 rows=cols=4, accum=0, M=identity, x=[1,2,3,4], res_base=0x100 -> words 0x100..0x103 = 1,2,3,4; busy 29 cycles; done 1 cycle; sat=0.
REQ-023 rows=2, cols=3, accum=1, M=[[1,1,1],[2,0,-1]], x=[5,6,7], y_old=[10,-4] -> y=[28,-1]; busy 4+2*6=16 cycles.
REQ-024 DATA_WIDTH=16, rows=cols=1, M=0x7FFF, x=0x7FFF -> result 0x00007FFF, sat=1 with done; a following job with M=x=2 -> result 4, sat=0.
REQ-025 start with cols=0, then with rows=65 -> err pulse each time, busy never asserted, BRAM_WE/BRAM_ADDR stay 0.
REQ-026 aresetn low during ROW_RD of row 1 in a 4x4 job -> all outputs 0 asynchronously, no done pulse; a restarted identical job produces the REQ-022 results.
REQ-027 start held high through a job and re-pulsed mid-job -> exactly one job per IDLE acceptance; FRAC_BITS=4 with acc=0x35 -> result 3.
